// File: rtl/aes_pkg.sv
// aes_pkg: shared AES helpers for the key schedule and the cipher datapath.
//   word_t       : 32-bit AES word, byte 0 in bits [0:7]
//   RCON_INIT    : round-constant value at the start of an expansion
//   sbox()       : forward S-box lookup
//   xtime()      : multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1
//   nr_of/nw_of  : round count and schedule length from key length NK
package aes_pkg;

    typedef logic [0:31] word_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // 8'h80 wraps to 8'h1b through the reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

    function automatic int nw_of(input int nk);
        return 4 * (nk + 7);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// aes_subword: combinational SubWord, four parallel S-box lookups.
//   i_word [0:31] : input word, byte 0 in bits [0:7]
//   o_word [0:31] : S-box substituted word, same byte order
module aes_subword
    import aes_pkg::*;
(
    input  logic [0:31] i_word,
    output logic [0:31] o_word
);

    assign o_word = {sbox(i_word[0:7]),   sbox(i_word[8:15]),
                     sbox(i_word[16:23]), sbox(i_word[24:31])};

endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES key expansion, one schedule word per clock,
// with the full schedule held in an internal word buffer and a registered
// 128-bit round-key read port.
//   clk, rst          : clock, synchronous active-high reset
//   start / ready     : expansion request, accepted while ready=1
//   key [0:32*NK-1]   : cipher key, word 0 in bits [0:31], sampled on accept
//   done              : one-cycle pulse after the last word is written
//   valid             : buffer holds the complete schedule of the last key
//   rk_idx / rk       : round-key index 0..NR, registered round key
module aes_key_sched
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [0:32*NK-1]  key,
    output logic              ready,
    output logic              done,
    output logic              valid,
    input  logic [3:0]        rk_idx,
    output logic [0:127]      rk
);

    localparam int NR = nr_of(NK);
    localparam int NW = nw_of(NK);

    localparam logic S_IDLE   = 1'b0;
    localparam logic S_EXPAND = 1'b1;

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_nk_check
        $fatal(1, "aes_key_sched: NK must be 4, 6 or 8");
    end

    logic       r_state;
    logic [5:0] r_i;
    logic [2:0] r_j;
    logic [7:0] r_rcon;
    logic       r_done;
    logic       r_valid;
    word_t      r_w [0:NW-1];
    logic [0:127] r_rk;

    word_t w_prev;
    word_t w_old;
    word_t w_sub_in;
    word_t w_sub_out;
    word_t w_f;
    word_t w_new;
    logic  w_last;
    logic  w_load;
    logic  w_step;
    logic [5:0] w_base;

    assign ready  = (r_state == S_IDLE);
    assign done   = r_done;
    assign valid  = r_valid;
    assign rk     = r_rk;

    assign w_load = (r_state == S_IDLE) && start;
    assign w_step = (r_state == S_EXPAND);
    assign w_last = (r_i == 6'(NW - 1));

    // Generation datapath: w[i] = w[i-NK] ^ f(w[i-1]); a single SubWord is
    // shared between the RotWord (j==0) and the NK=8 mid-block (j==4) cases.
    assign w_prev   = r_w[r_i - 6'd1];
    assign w_old    = r_w[r_i - 6'(NK)];
    assign w_sub_in = (r_j == 3'd0) ? {w_prev[8:31], w_prev[0:7]} : w_prev;

    aes_subword u_subword (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_f = w_prev;
        if (r_j == 3'd0)
            w_f = w_sub_out ^ {r_rcon, 24'h000000};
        else if (NK == 8 && r_j == 3'd4)
            w_f = w_sub_out;
    end

    assign w_new = w_old ^ w_f;

    // Control: state, word counter, position within key block, round constant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= 6'd0;
            r_j     <= 3'd0;
            r_rcon  <= RCON_INIT;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_state <= S_EXPAND;
                r_i     <= 6'(NK);
                r_j     <= 3'd0;
                r_rcon  <= RCON_INIT;
                r_valid <= 1'b0;
            end else if (w_step) begin
                if (r_j == 3'd0)
                    r_rcon <= xtime(r_rcon);
                r_i <= r_i + 6'd1;
                r_j <= (r_j == 3'(NK - 1)) ? 3'd0 : r_j + 3'd1;
                if (w_last) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    // Schedule buffer: key load fills w[0..NK-1], each expand cycle fills w[i].
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int k = 0; k < NK; k++)
                r_w[k] <= key[32*k +: 32];
        end else if (w_step) begin
            r_w[r_i] <= w_new;
        end
    end

    // Read port: four consecutive buffer words, zero for out-of-range indices.
    assign w_base = {rk_idx, 2'b00};

    always_ff @(posedge clk) begin
        if (rst)
            r_rk <= '0;
        else if (rk_idx > 4'(NR))
            r_rk <= '0;
        else
            r_rk <= {r_w[w_base], r_w[w_base | 6'd1],
                     r_w[w_base | 6'd2], r_w[w_base | 6'd3]};
    end

endmodule
